// File: rtl/lz77_pkg.sv
// Shared types for the LZ77 encode scheduler: FSM state encoding and the codeword record.
package lz77_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ENC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

  localparam int SRC_W  = 2;
  localparam int OFF_W  = 4;
  localparam int LEN_W  = 3;
  localparam int CHAR_W = 8;

  localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
    logic              last;
  } codeword_t;

endpackage

// File: rtl/lz77_cw_fifo.sv
// Synchronous codeword FIFO; a push into a full FIFO is dropped and latches a sticky overflow flag.
module lz77_cw_fifo
  import lz77_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  codeword_t push_cw,
  input  logic      pop,
  output codeword_t head_cw,
  output logic      empty,
  output logic      ovf
);

  localparam int AW = $clog2(DEPTH);

  codeword_t      mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           ovf_r;
  logic           full_s;
  logic           do_pop_s;
  logic           do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push_s = push && (!full_s || do_pop_s);
  assign head_cw   = mem_r[rd_ptr_r[AW-1:0]];
  assign ovf       = ovf_r;

  // Pointer and overflow-flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      if (push && !do_push_s) ovf_r <= 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_cw;
  end

endmodule

// File: rtl/lz77_encode_scheduler.sv
// Round-robin scheduler sharing one LZ77 encoder core between NREQ frame sources.
// Optional ENC-phase watchdog enabled by defining LZ77_SCHED_TIMEOUT_EN.
module lz77_encode_scheduler
  import lz77_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int FRAME_LEN = 2048,
  parameter int OUT_DEPTH = 8,
  parameter int TMO_CYC   = 8192
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            core_reset,
  output logic [7:0]      core_chardata,
  input  logic            core_valid,
  input  logic [3:0]      core_offset,
  input  logic [2:0]      core_match_len,
  input  logic [7:0]      core_char_nxt,
  input  logic            core_finish,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_src,
  output logic [3:0]      out_offset,
  output logic [2:0]      out_match_len,
  output logic [7:0]      out_char,
  output logic            out_last,
  output logic            busy,
  output logic            err,
  output logic            ovf
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           state_r, state_s;
  logic [NREQ-1:0]  gnt_r;
  logic [SRC_W-1:0] src_r, rr_ptr_r, win_idx_s, idx_s;
  logic [3:0]       req4_s;
  logic             win_found_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       chardata_r;
  logic             tmo_hit_s, fifo_empty_s, push_s;
  codeword_t        push_cw_s, head_cw_s;

  // Round-robin search: first requester at or after the pointer.
  always_comb begin
    req4_s      = 4'(req);
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = SRC_W'((int'(rr_ptr_r) + k) % NREQ);
      if (!win_found_s && req4_s[idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (win_found_s) state_s = ST_CRST; else state_s = ST_IDLE;
      ST_CRST:  state_s = ST_LOAD;
      ST_LOAD: begin
        if (!in_valid)              state_s = ST_ABORT;
        else if (cnt_r == LAST_CNT) state_s = ST_ENC;
        else                        state_s = ST_LOAD;
      end
      ST_ENC: begin
        if (core_finish)    state_s = ST_DRAIN;
        else if (tmo_hit_s) state_s = ST_ABORT;
        else                state_s = ST_ENC;
      end
      ST_DRAIN: if (fifo_empty_s) state_s = ST_IDLE; else state_s = ST_DRAIN;
      ST_ABORT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, grant, pointer and char-path registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      gnt_r      <= '0;
      src_r      <= '0;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      chardata_r <= 8'h00;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && win_found_s) begin
        gnt_r    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
        src_r    <= win_idx_s;
        rr_ptr_r <= SRC_W'((int'(win_idx_s) + 1) % NREQ);
      end else if (state_s == ST_IDLE || state_s == ST_ABORT) begin
        gnt_r <= '0;
      end
      if (state_r == ST_CRST) begin
        cnt_r <= '0;
      end else if (state_r == ST_LOAD && in_valid) begin
        cnt_r      <= cnt_r + CNT_W'(1);
        chardata_r <= in_data;
      end
    end
  end

`ifdef LZ77_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Cycles spent in ENC waiting for core_finish.
  always_ff @(posedge clk) begin
    if (reset)                  tmo_cnt_r <= '0;
    else if (state_r == ST_ENC) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    else                        tmo_cnt_r <= '0;
  end

  assign tmo_hit_s = (state_r == ST_ENC) && (tmo_cnt_r == TMO_W'(TMO_CYC - 1));
`else
  // Without the watchdog ENC never times out; the comparison is constant false.
  assign tmo_hit_s = (TMO_CYC < 0);
`endif

  assign push_s    = (state_r == ST_ENC) && core_valid;
  assign push_cw_s = {src_r, core_offset, core_match_len, core_char_nxt, (core_char_nxt == END_CHAR)};

  lz77_cw_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .push_cw (push_cw_s),
    .pop     (out_ready),
    .head_cw (head_cw_s),
    .empty   (fifo_empty_s),
    .ovf     (ovf)
  );

  assign gnt           = gnt_r;
  assign core_chardata = chardata_r;
  assign in_ready      = (state_r == ST_LOAD);
  assign core_reset    = !(state_r == ST_LOAD || state_r == ST_ENC);
  assign busy          = (state_r != ST_IDLE);
  assign err           = (state_r == ST_ABORT);
  assign out_valid     = !fifo_empty_s;
  assign out_src       = head_cw_s.src;
  assign out_offset    = head_cw_s.offset;
  assign out_match_len = head_cw_s.match_len;
  assign out_char      = head_cw_s.char_nxt;
  assign out_last      = head_cw_s.last;

endmodule

// File: tb/tb_lz77_encode_scheduler.sv
// Self-checking bench for lz77_encode_scheduler: frame table plus hand-written abort/overflow/reset/timeout cases.
module tb_lz77_encode_scheduler;

  localparam int NREQ = 2;
  localparam int FL   = 16;
  localparam int DEP  = 4;
  localparam int TMO  = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, core_reset;
  logic [7:0] core_chardata;
  logic       core_valid = 1'b0;
  logic [3:0] core_offset = 4'h0;
  logic [2:0] core_match_len = 3'd0;
  logic [7:0] core_char_nxt = 8'h00;
  logic       core_finish = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_src;
  logic [3:0] out_offset;
  logic [2:0] out_match_len;
  logic [7:0] out_char;
  logic       out_last, busy, err, ovf;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_e;

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_gnt;
    logic [1:0] src;
    int         ncw;
    logic [7:0] seed;
  } frame_t;

  frame_t frames[6];

  lz77_encode_scheduler #(.NREQ(NREQ), .FRAME_LEN(FL), .OUT_DEPTH(DEP), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_reset(core_reset), .core_chardata(core_chardata),
    .core_valid(core_valid), .core_offset(core_offset), .core_match_len(core_match_len),
    .core_char_nxt(core_char_nxt), .core_finish(core_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_offset(out_offset),
    .out_match_len(out_match_len), .out_char(out_char), .out_last(out_last),
    .busy(busy), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted codeword must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL cw_unexpected: got %0h expected none", {out_src, out_offset, out_match_len, out_char, out_last});
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_src, out_offset, out_match_len, out_char, out_last} !== exp_e) begin
          bad++;
          $display("FAIL cw: got %0h expected %0h", {out_src, out_offset, out_match_len, out_char, out_last}, exp_e);
        end
      end
    end
  end

  task automatic start_frame(input logic [1:0] r, input logic [1:0] eg);
    req = r;
    tick();
    chk("gnt_crst", 32'(gnt), 32'(eg));
    chk("in_ready_crst", 32'(in_ready), 32'd0);
    chk("core_reset_crst", 32'(core_reset), 32'd1);
    chk("busy_crst", 32'(busy), 32'd1);
    req = 2'b00;
    tick();
    chk("in_ready_load", 32'(in_ready), 32'd1);
    chk("core_reset_load", 32'(core_reset), 32'd0);
    chk("gnt_load", 32'(gnt), 32'(eg));
  endtask

  task automatic load_chars(input logic [7:0] seed, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = seed + 8'(i);
      tick();
      chk("core_chardata", 32'(core_chardata), 32'(seed + 8'(i)));
      chk("in_ready_beat", 32'(in_ready), (i < FL - 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic encode(input logic [1:0] src, input int ncw, input logic [7:0] seed);
    logic [7:0] ch;
    for (int k = 0; k < ncw; k++) begin
      ch = (k == ncw - 1) ? 8'h24 : (seed ^ 8'(k));
      core_valid = 1'b1;
      core_offset = 4'(k);
      core_match_len = 3'(k);
      core_char_nxt = ch;
      if (exp_q.size() < DEP) exp_q.push_back({src, 4'(k), 3'(k), ch, (ch == 8'h24)});
      tick();
      if (k == 0) chk("core_reset_enc", 32'(core_reset), 32'd0);
    end
    core_valid = 1'b0;
    core_finish = 1'b1;
    tick();
    core_finish = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(busy), 32'd0);
    chk("gnt_idle", 32'(gnt), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input frame_t f);
    start_frame(f.req, f.exp_gnt);
    load_chars(f.seed, FL);
    encode(f.src, f.ncw, f.seed);
    wait_idle(50);
  endtask

  task automatic check_reset_state();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_chardata", 32'(core_chardata), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frames[0] = '{req: 2'b01, exp_gnt: 2'b01, src: 2'd0, ncw: 3, seed: 8'h41};
    frames[1] = '{req: 2'b10, exp_gnt: 2'b10, src: 2'd1, ncw: 2, seed: 8'h51};
    frames[2] = '{req: 2'b11, exp_gnt: 2'b01, src: 2'd0, ncw: 4, seed: 8'h61};
    frames[3] = '{req: 2'b11, exp_gnt: 2'b10, src: 2'd1, ncw: 1, seed: 8'h71};
    frames[4] = '{req: 2'b11, exp_gnt: 2'b01, src: 2'd0, ncw: 5, seed: 8'h43};
    frames[5] = '{req: 2'b01, exp_gnt: 2'b01, src: 2'd0, ncw: 3, seed: 8'h53};

    reset = 1'b1;
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();

    // Pointer ends at 1 after frames[5].
    for (int i = 0; i < 6; i++) run_frame(frames[i]);

    // Stream gap at char 5 aborts the frame.
    start_frame(2'b11, 2'b10);
    load_chars(8'h30, 5);
    tick();
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("abort_err_pulse", 32'(err), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_frame('{req: 2'b11, exp_gnt: 2'b01, src: 2'd0, ncw: 2, seed: 8'h45});

    // Stalled consumer: only DEP of 8 codewords survive, ovf sticks.
    out_ready = 1'b0;
    start_frame(2'b11, 2'b10);
    load_chars(8'h50, FL);
    encode(2'd1, 8, 8'h55);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_out_valid", 32'(out_valid), 32'd1);
    repeat (5) tick();
    chk("drain_waits", 32'(busy), 32'd1);
    chk("drain_head", 32'({out_offset, out_char}), 32'({4'd0, 8'h55}));
    out_ready = 1'b1;
    wait_idle(50);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-LOAD discards everything, including the RR pointer.
    start_frame(2'b01, 2'b01);
    load_chars(8'h20, 3);
    reset = 1'b1;
    exp_q.delete();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_reset_state();
    reset = 1'b0;
    tick();
    run_frame('{req: 2'b11, exp_gnt: 2'b01, src: 2'd0, ncw: 2, seed: 8'h47});

    // Core never finishes.
    start_frame(2'b01, 2'b01);
    load_chars(8'h10, FL);
`ifdef LZ77_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      while (!err && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_cycle", 32'(n), 32'd32);
      chk("tmo_gnt", 32'(gnt), 32'd0);
      tick();
      chk("tmo_idle", 32'(busy), 32'd0);
    end
`else
    repeat (40) tick();
    chk("no_tmo_busy", 32'(busy), 32'd1);
    chk("no_tmo_err", 32'(err), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
